// File: rtl/c432_key_loader.sv
// c432_key_loader: serial key load, per-group parity check and holding register for the MUX4-locked c432
// Define KEY_LOCKOUT_EN to lock the loader after MAX_FAIL consecutive failed loads.
module c432_key_loader #(
  parameter int KEY_W      = 32,
  parameter int GRP_W      = 4,
  parameter int MAX_FAIL   = 3,
  parameter int FAIL_CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start_i,
  input  logic                  zeroize_i,
  input  logic                  key_vld_i,
  input  logic                  key_bit_i,
  output logic                  key_rdy_o,
  output logic [KEY_W-1:0]      key_out_o,
  output logic                  key_valid_o,
  output logic                  load_err_o,
  output logic                  locked_o,
  output logic [FAIL_CNT_W-1:0] fail_cnt_o
);
  localparam int NGRP  = KEY_W / GRP_W;
  localparam int NBITS = KEY_W + NGRP;
  localparam int CNT_W = $clog2(NBITS);
`ifdef KEY_LOCKOUT_EN
  localparam logic [FAIL_CNT_W-1:0] FAIL_MAX = FAIL_CNT_W'(MAX_FAIL);
`else
  localparam logic [FAIL_CNT_W-1:0] FAIL_MAX = {FAIL_CNT_W{1'b1}} | FAIL_CNT_W'(MAX_FAIL);
`endif
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ARMED, LOCKED} state_e;
  state_e                  state_q;
  logic [KEY_W-1:0]        shift_q, key_out_q;
  logic [NGRP-1:0]         par_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic                    key_rdy_q, key_valid_q, load_err_q, locked_q;
  logic                    par_ok, lock_d;
  assign key_rdy_o   = key_rdy_q;
  assign key_out_o   = key_out_q;
  assign key_valid_o = key_valid_q;
  assign load_err_o  = load_err_q;
  assign locked_o    = locked_q;
  assign fail_cnt_o  = fail_cnt_q;
  always_comb begin
    par_ok = 1'b1;
    for (int g = 0; g < NGRP; g++) par_ok = par_ok & (par_q[g] == ^shift_q[g*GRP_W +: GRP_W]);
    fail_cnt_d = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
`ifdef KEY_LOCKOUT_EN
    lock_d = (fail_cnt_d == FAIL_MAX);
`else
    lock_d = 1'b0;
`endif
  end
  // Bits arrive LSB first, so right-shifting leaves the first key bit in [0] (p1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      par_q       <= '0;
      cnt_q       <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      key_rdy_q   <= 1'b0;
      load_err_q  <= 1'b0;
      locked_q    <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      load_err_q <= 1'b0;
      if (zeroize_i && state_q != LOCKED) begin
        state_q     <= IDLE;
        shift_q     <= '0;
        par_q       <= '0;
        cnt_q       <= '0;
        key_out_q   <= '0;
        key_valid_q <= 1'b0;
        key_rdy_q   <= 1'b0;
      end else if (load_start_i && (state_q == IDLE || state_q == ARMED || state_q == SHIFT)) begin
        state_q     <= SHIFT;
        shift_q     <= '0;
        par_q       <= '0;
        cnt_q       <= '0;
        key_valid_q <= 1'b0;
        key_rdy_q   <= 1'b1;
      end else if (state_q == SHIFT && key_vld_i && key_rdy_q) begin
        if (cnt_q < CNT_W'(KEY_W)) shift_q <= {key_bit_i, shift_q[KEY_W-1:1]};
        else par_q <= {key_bit_i, par_q[NGRP-1:1]};
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NBITS - 1)) begin
          state_q   <= CHECK;
          key_rdy_q <= 1'b0;
        end
      end else if (state_q == CHECK) begin
        if (par_ok) begin
          state_q     <= ARMED;
          key_out_q   <= shift_q;
          key_valid_q <= 1'b1;
          fail_cnt_q  <= '0;
        end else begin
          state_q     <= lock_d ? LOCKED : IDLE;
          key_out_q   <= '0;
          key_valid_q <= 1'b0;
          load_err_q  <= 1'b1;
          locked_q    <= lock_d;
          fail_cnt_q  <= fail_cnt_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_c432_key_loader.sv
// tb_c432_key_loader: randomized self-checking bench against a behavioural key-loader model
module tb_c432_key_loader;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        load_start = 1'b0, zeroize = 1'b0, key_vld = 1'b0, key_bit = 1'b0;
  logic        key_rdy, key_valid, load_err, locked;
  logic [31:0] key_out;
  logic [1:0]  fail_cnt;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] mdl_key = '0;
  logic        mdl_valid = 1'b0, mdl_locked = 1'b0;
  int          mdl_fail = 0;

  c432_key_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start_i(load_start), .zeroize_i(zeroize),
    .key_vld_i(key_vld), .key_bit_i(key_bit), .key_rdy_o(key_rdy), .key_out_o(key_out),
    .key_valid_o(key_valid), .load_err_o(load_err), .locked_o(locked), .fail_cnt_o(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gen_par(input logic [31:0] k);
    logic [7:0] p;
    for (int g = 0; g < 8; g++) begin
      int ones = 0;
      for (int j = 0; j < 4; j++) ones += int'((k >> (4 * g + j)) & 32'd1);
      p[g] = (ones % 2) == 1;
    end
    return p;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_key"}, key_out, mdl_key);
    chk({tag, "_valid"}, {31'd0, key_valid}, {31'd0, mdl_valid});
    chk({tag, "_fail"}, {30'd0, fail_cnt}, mdl_fail);
    chk({tag, "_locked"}, {31'd0, locked}, {31'd0, mdl_locked});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_vld = 1'b0; load_start = 1'b0; zeroize = 1'b0;
    #2;
    mdl_key = '0; mdl_valid = 1'b0; mdl_fail = 0; mdl_locked = 1'b0;
    chk_all("rst");
    chk("rst_rdy", {31'd0, key_rdy}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  // One complete load: optional random gaps, optional abort/restart, optional zeroize in CHECK.
  task automatic load(input logic [31:0] k, input logic [7:0] flip, input bit gaps,
                      input int abort_at, input bit zero_at_check);
    logic [31:0] old = mdl_key;
    logic [7:0]  par = gen_par(k) ^ flip;
    bit          ok = (flip == 8'd0);
    bit          exp_err;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    mdl_valid = 1'b0;
    chk("rdy_start", {31'd0, key_rdy}, 32'd1);
    chk("valid_drop", {31'd0, key_valid}, 32'd0);
    if (abort_at > 0) begin
      for (int i = 0; i < abort_at; i++) begin
        key_vld = 1'b1; key_bit = 1'($urandom);
        tick();
      end
      key_vld = 1'b0; load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("rdy_restart", {31'd0, key_rdy}, 32'd1);
    end
    for (int i = 0; i < 40; i++) begin
      int ng = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < ng; j++) begin
        key_vld = 1'b0;
        tick();
        chk("rdy_gap", {31'd0, key_rdy}, 32'd1);
      end
      key_vld = 1'b1;
      key_bit = (i < 32) ? k[i] : par[i-32];
      tick();
      if (i < 39) chk("rdy_shift", {31'd0, key_rdy}, 32'd1);
      chk("hold", key_out, old);
    end
    key_vld = 1'b0;
    chk("rdy_check", {31'd0, key_rdy}, 32'd0);
    chk("valid_check", {31'd0, key_valid}, 32'd0);
    zeroize = zero_at_check;
    tick();
    zeroize = 1'b0;
    exp_err = !zero_at_check && !ok;
    if (zero_at_check) begin
      mdl_key = '0; mdl_valid = 1'b0;
    end else if (ok) begin
      mdl_key = k; mdl_valid = 1'b1; mdl_fail = 0;
    end else begin
      mdl_key = '0; mdl_valid = 1'b0;
      mdl_fail = (mdl_fail < 3) ? mdl_fail + 1 : 3;
`ifdef KEY_LOCKOUT_EN
      mdl_locked = (mdl_fail == 3);
`endif
    end
    chk_all("commit");
    chk("err", {31'd0, load_err}, {31'd0, exp_err});
    chk("rdy_after", {31'd0, key_rdy}, 32'd0);
    tick();
    chk("err_pulse", {31'd0, load_err}, 32'd0);
    chk_all("after");
  endtask

  initial begin
    do_reset();
    load(32'hA5C3_1E7F, 8'h00, 1'b0, 0, 1'b0);
    load(32'hA5C3_1E7F, 8'h00, 1'b1, 0, 1'b0);
    load(32'hA5C3_1E7F, 8'h20, 1'b0, 0, 1'b0);
    load(32'hA5C3_1E7F, 8'h00, 1'b1, 0, 1'b0);
    for (int r = 0; r < 6; r++) load($urandom, 8'h00, r[0], 0, 1'b0);
    load($urandom, 8'h00, 1'b1, int'($urandom_range(1, 38)), 1'b0);
    load($urandom, 8'h00, 1'b0, 0, 1'b1);
    load($urandom, 8'h00, 1'b0, 0, 1'b0);
    load($urandom, 8'h00, 1'b0, 0, 1'b1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      key_vld = 1'b1; key_bit = 1'($urandom);
      tick();
    end
    do_reset();
`ifdef KEY_LOCKOUT_EN
    for (int r = 0; r < 3; r++) load($urandom, 8'(1 << r), 1'b0, 0, 1'b0);
    chk("locked_set", {31'd0, locked}, 32'd1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      key_vld = 1'b1; key_bit = 1'($urandom);
      tick();
      chk("lock_rdy", {31'd0, key_rdy}, 32'd0);
    end
    key_vld = 1'b0;
    tick();
    chk_all("lock_load");
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk_all("lock_zero");
    do_reset();
`else
    for (int r = 0; r < 4; r++) load($urandom, 8'(1 << r), r[0], 0, 1'b0);
    chk("sat_fail", {30'd0, fail_cnt}, 32'd3);
    chk("no_lock", {31'd0, locked}, 32'd0);
`endif
    load($urandom, 8'h00, 1'b1, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
